// File: rtl/tug_light_bar_if.sv
// Tug-of-war playfield bus: key levels and round restart in; lights, win flags and scores out.
interface tug_light_bar_if #(
    parameter int N       = 9,
    parameter int SCORE_W = 4
);
    logic               gameReset;
    logic               L;
    logic               R;
    logic [N-1:0]       lights;
    logic               leftWin;
    logic               rightWin;
    logic [SCORE_W-1:0] leftScore;
    logic [SCORE_W-1:0] rightScore;

    modport master (
        output gameReset, L, R,
        input  lights, leftWin, rightWin, leftScore, rightScore
    );

    modport slave (
        input  gameReset, L, R,
        output lights, leftWin, rightWin, leftScore, rightScore
    );
endinterface

// File: rtl/tug_light_bar.sv
// N-light tug-of-war playfield: edge-detected L/R moves, win detection, saturating scores, optional auto restart.
// One-cycle latency from sampled key edge to lights; outputs decode registered state only, no backpressure.
module tug_light_bar #(
    parameter int N            = 9,
    parameter int SCORE_W      = 4,
    parameter int AUTO_RESTART = 0,
    parameter int RESTART_CYC  = 50
) (
    input  logic             Clock,
    input  logic             Reset,
    tug_light_bar_if.slave   bus
);
    localparam int PW  = $clog2(N);
    localparam int C   = (N - 1) / 2;
    localparam int RCW = $clog2(RESTART_CYC + 1);

    typedef enum logic [1:0] {PLAY, L_WIN, R_WIN} state_t;

    state_t             state;
    logic [PW-1:0]      pos;
    logic [RCW-1:0]     rc;
    logic               Lq;
    logic               Rq;
    logic [SCORE_W-1:0] leftScore;
    logic [SCORE_W-1:0] rightScore;

    logic lp;
    logic rp;
    logic moveL;
    logic moveR;

    assign lp    = bus.L & ~Lq;
    assign rp    = bus.R & ~Rq;
    // Simultaneous presses cancel out.
    assign moveL = lp & ~rp;
    assign moveR = rp & ~lp;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= PLAY;
            pos        <= PW'(C);
            rc         <= '0;
            Lq         <= 1'b1;
            Rq         <= 1'b1;
            leftScore  <= '0;
            rightScore <= '0;
        end else begin
            Lq <= bus.L;
            Rq <= bus.R;
            if (bus.gameReset) begin
                state <= PLAY;
                pos   <= PW'(C);
                rc    <= '0;
            end else begin
                case (state)
                    PLAY: begin
                        rc <= '0;
                        if (moveL) begin
                            if (pos == PW'(N - 1)) begin
                                state <= L_WIN;
                                if (leftScore != '1) leftScore <= leftScore + 1'b1;
                            end else begin
                                pos <= pos + 1'b1;
                            end
                        end else if (moveR) begin
                            if (pos == '0) begin
                                state <= R_WIN;
                                if (rightScore != '1) rightScore <= rightScore + 1'b1;
                            end else begin
                                pos <= pos - 1'b1;
                            end
                        end
                    end
                    L_WIN, R_WIN: begin
                        // Without auto restart the round stays won until gameReset.
                        if (AUTO_RESTART != 0) begin
                            if (rc == RCW'(RESTART_CYC - 1)) begin
                                state <= PLAY;
                                pos   <= PW'(C);
                                rc    <= '0;
                            end else begin
                                rc <= rc + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= PLAY;
                        pos   <= PW'(C);
                        rc    <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        bus.lights = '0;
        if (state == PLAY) bus.lights[pos] = 1'b1;
    end

    assign bus.leftWin    = (state == L_WIN);
    assign bus.rightWin   = (state == R_WIN);
    assign bus.leftScore  = leftScore;
    assign bus.rightScore = rightScore;
endmodule

// File: tb/tb_tug_light_bar.sv
// Directed bench: instance A (N=5, SCORE_W=2, manual restart), instance B (N=5, auto restart after 4 cycles).
module tb_tug_light_bar;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   passCnt = 0;
    int   totalCnt = 0;

    always #5 Clock = ~Clock;

    tug_light_bar_if #(.N(5), .SCORE_W(2)) busA ();
    tug_light_bar_if #(.N(5), .SCORE_W(4)) busB ();

    tug_light_bar #(.N(5), .SCORE_W(2), .AUTO_RESTART(0), .RESTART_CYC(50)) dutA (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (busA.slave)
    );

    tug_light_bar #(.N(5), .SCORE_W(4), .AUTO_RESTART(1), .RESTART_CYC(4)) dutB (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (busB.slave)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One press on A: one high sample, checked right after it, then one low sample.
    task automatic pressA(input bit left, input string tag, input logic [4:0] expLights);
        if (left) busA.L = 1'b1; else busA.R = 1'b1;
        tick();
        check(tag, {27'd0, busA.lights}, {27'd0, expLights});
        busA.L = 1'b0;
        busA.R = 1'b0;
        tick();
    endtask

    task automatic restartA();
        busA.gameReset = 1'b1;
        tick();
        busA.gameReset = 1'b0;
    endtask

    task automatic leftWinA(input logic [1:0] expScore, input string tag);
        restartA();
        pressA(1'b1, {tag, "_p1"}, 5'b01000);
        pressA(1'b1, {tag, "_p2"}, 5'b10000);
        pressA(1'b1, {tag, "_p3"}, 5'b00000);
        check({tag, "_score"}, {30'd0, busA.leftScore}, {30'd0, expScore});
    endtask

    initial begin
        busA.gameReset = 1'b0; busA.L = 1'b0; busA.R = 1'b0;
        busB.gameReset = 1'b0; busB.L = 1'b0; busB.R = 1'b0;

        // Reset held low for two edges.
        tick(2);
        Reset = 1'b1;
        tick();
        check("rst_lights", {27'd0, busA.lights}, 32'b00100);
        check("rst_lscore", {30'd0, busA.leftScore}, 32'd0);
        check("rst_rscore", {30'd0, busA.rightScore}, 32'd0);
        check("rst_wins", {30'd0, busA.leftWin, busA.rightWin}, 32'd0);

        // A held key moves only once.
        busA.L = 1'b1;
        tick();
        check("hold_first", {27'd0, busA.lights}, 32'b01000);
        tick(4);
        check("hold_5cyc", {27'd0, busA.lights}, 32'b01000);
        busA.L = 1'b0;
        tick();

        // Left win from centre.
        restartA();
        check("grst_centre", {27'd0, busA.lights}, 32'b00100);
        pressA(1'b1, "lwin_p1", 5'b01000);
        pressA(1'b1, "lwin_p2", 5'b10000);
        pressA(1'b1, "lwin_p3", 5'b00000);
        check("lwin_flag", {30'd0, busA.leftWin, busA.rightWin}, 32'b10);
        check("lwin_score", {30'd0, busA.leftScore}, 32'd1);
        pressA(1'b1, "lwin_ignL", 5'b00000);
        pressA(1'b0, "lwin_ignR", 5'b00000);
        check("lwin_hold", {30'd0, busA.leftWin, busA.leftScore}, 32'b101);

        // Simultaneous press is ignored; a lone right press then moves right.
        restartA();
        check("grst_clear", {30'd0, busA.leftWin, busA.rightWin}, 32'd0);
        check("grst_keep", {30'd0, busA.leftScore}, 32'd1);
        busA.L = 1'b1; busA.R = 1'b1;
        tick();
        check("both_press", {27'd0, busA.lights}, 32'b00100);
        busA.L = 1'b0; busA.R = 1'b0;
        tick();
        pressA(1'b0, "right_move", 5'b00010);

        // Saturation with a 2-bit score.
        leftWinA(2'd2, "win2");
        leftWinA(2'd3, "win3");
        leftWinA(2'd3, "win4_sat");

        Reset = 1'b0;
        tick();
        check("rst2_scores", {busA.leftScore, busA.rightScore}, 32'd0);
        check("rst2_lights", {27'd0, busA.lights}, 32'b00100);
        Reset = 1'b1;
        tick();

        // gameReset mid-round, then held high while a key rises.
        pressA(1'b1, "pos3", 5'b01000);
        restartA();
        check("grst_pos3", {27'd0, busA.lights}, 32'b00100);
        busA.gameReset = 1'b1; busA.L = 1'b1;
        tick();
        check("grst_held", {27'd0, busA.lights}, 32'b00100);
        busA.gameReset = 1'b0; busA.L = 1'b0;
        tick();

        // Key held through Reset release gives no press.
        busA.L = 1'b1;
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        tick(2);
        check("hold_thru_rst", {27'd0, busA.lights}, 32'b00100);
        busA.L = 1'b0;
        tick();
        pressA(1'b1, "after_rst_press", 5'b01000);

        // Instance B: right win with automatic restart after four win cycles.
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        busB.R = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            busB.R = 1'b1;
            tick();
            busB.R = 1'b0;
            if (k == 0) check("b_p1", {27'd0, busB.lights}, 32'b00010);
            if (k == 1) check("b_p2", {27'd0, busB.lights}, 32'b00001);
            if (k < 2) tick();
        end
        check("b_win_entry", {30'd0, busB.leftWin, busB.rightWin}, 32'b01);
        check("b_win_score", {28'd0, busB.rightScore}, 32'd1);
        check("b_win_lights", {27'd0, busB.lights}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("b_win_hold", {31'd0, busB.rightWin}, 32'd1);
        end
        tick();
        check("b_restart_flag", {31'd0, busB.rightWin}, 32'd0);
        check("b_restart_lights", {27'd0, busB.lights}, 32'b00100);
        check("b_restart_score", {28'd0, busB.rightScore}, 32'd1);
        busB.gameReset = 1'b1;
        tick();
        busB.gameReset = 1'b0;
        check("b_grst_scores", {24'd0, busB.leftScore, busB.rightScore}, 32'h01);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/tug_light_bar.md
# tug_light_bar

Parametrised N-light playfield for the tug-of-war game. It replaces the per-light cells with a single block that holds the lit position and edge-detects the L/R keys. It also decides the winner, keeps per-side scores and can optionally restart the round on its own. It sits between the key synchronisers and the LEDR/HEX drivers.

## Interface
- N, default 9: number of lights; odd, 3..31; centre index C = (N-1)/2.
- SCORE_W, default 4: width of each score counter.
- AUTO_RESTART, default 0: 1 = leave win state automatically after RESTART_CYC cycles; 0 = wait for gameReset.
- RESTART_CYC, default 50: cycles spent in win state before auto restart; ≥2; counter width $clog2(RESTART_CYC+1).
- Clock  in  1  single system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low; clears all state including scores.
- gameReset  in  1  synchronous, active-high; starts a new round and keeps the scores.
- L  in  1  left key level; high while pressed; already synchronised to Clock.
- R  in  1  right key level; high while pressed; already synchronised.
- lights  out  N  one-hot lit light; bit N-1 is leftmost, bit 0 is rightmost; all zero in win states.
- leftWin  out  1  high while in L_WIN.
- rightWin  out  1  high while in R_WIN.
- leftScore  out  SCORE_W  left wins, saturating.
- rightScore  out  SCORE_W  right wins, saturating.

## Operation
- Edge detect: registers Lq and Rq hold the previous levels.
  - lp = L & ~Lq; rp = R & ~Rq.
  - Lq and Rq reset to 1, so a key held through reset release gives no press.
- Effective press: lp & ~rp moves left; rp & ~lp moves right; lp & rp in the same cycle is ignored.
- State register pos, width $clog2(N), reset value C.
- FSM states PLAY, L_WIN, R_WIN; reset state PLAY.
- PLAY:
  - Left press with pos < N-1: pos += 1.
  - Left press with pos == N-1: go to L_WIN; leftScore += 1.
  - Right press with pos > 0: pos -= 1.
  - Right press with pos == 0: go to R_WIN; rightScore += 1.
- L_WIN / R_WIN:
  - All key presses are ignored; lights = 0.
  - If AUTO_RESTART = 1: restart counter rc counts up from 0. When rc == RESTART_CYC-1, go to PLAY, pos = C, rc = 0.
- Scores:
  - Increment exactly once, on the edge that enters the win state.
  - Saturate at 2^SCORE_W-1.
  - Cleared only by Reset.
- Priority (highest first):
  1. Reset: everything to reset values.
  2. gameReset: PLAY, pos = C, rc = 0, scores unchanged; Lq/Rq still sample L/R.
  3. FSM transition.
- Reset values: lights = one-hot at C; leftWin = rightWin = 0; scores = 0.
- lights, leftWin and rightWin are combinational decodes of registered state only. No input-to-output combinational path.

## Timing
- A press whose rising edge is sampled at clock edge k updates pos/state at edge k. lights changes after edge k, so latency is 1 cycle.
- A key held high gives one press only. The next press needs at least one low sample.
- Back-to-back presses are at most one every 2 cycles per key (high, low, high).
- Win entry: the edge that sees the final press sets leftWin/rightWin and the score at the same edge.
- Auto restart: after RESTART_CYC edges in the win state, PLAY resumes with lights at C.
- gameReset asserted in any state: PLAY at the next edge. Held high, it holds PLAY with pos = C and ignores presses.
- Reset asserted mid-round or in a win state: everything is cleared at that edge.

## Test plan
1. N=5. Reset low 2 cycles then high → lights = 5'b00100, scores 0. Hold L high 5 cycles → only one move, lights = 5'b01000.
2. N=5. Three left presses, each 1 high + 1 low cycle, from centre → lights 01000, then 10000, then 0 with leftWin = 1 and leftScore = 1. Further L/R presses → no change.
3. L and R rise in the same cycle → pos unchanged. Next, R alone → lights shift one place right.
4. AUTO_RESTART=1, RESTART_CYC=4, right win → rightWin high exactly 4 cycles, then lights = 00100 and rightScore = 1. Then gameReset → scores remain 1.
5. SCORE_W=2, four left wins → leftScore saturates at 3. Reset low → both scores 0 and lights at centre.
6. gameReset pulsed at pos = 3 → next cycle lights = 00100. L held high through Reset release → no press registered.
